// File: rtl/execute_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : y86_pkg                                                        |
// | Purpose   : Shared Y86-64 constants and types for the execute stage:       |
// |             icodes, ALU functions, condition selectors, status codes,      |
// |             the "no register" id, the registered result record and the     |
// |             branch/cmov condition evaluator.                               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // ALU functions, encoded as the OPq ifun values
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    XOR = 2'd3
  } alu_fn_e;

  // Condition selectors (ifun of cmovXX / jXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Everything the memory stage receives for one instruction
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } exec_res_t;

  localparam exec_res_t RES_RESET = '{stat: 3'd0, icode: 4'd0, cnd: 1'b0,
                                      valE: 64'd0, valA: 64'd0,
                                      dstE: RNONE, dstM: RNONE};

  // cc is {ZF, SF, OF}
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    logic res;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   res = 1'b1;
      C_LE:    res = (sf ^ of) | zf;
      C_L:     res = sf ^ of;
      C_E:     res = zf;
      C_NE:    res = ~zf;
      C_GE:    res = ~(sf ^ of);
      C_G:     res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : execute_stage_if                                               |
// | Purpose   : Decode->execute and execute->memory handshakes plus the        |
// |             condition-code view.                                           |
// |   master : producer side (drives in_*, out_ready)                          |
// |   slave  : execute stage (drives in_ready, out_*, cc)                      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_stat;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [63:0] in_valA;
  logic [63:0] in_valB;
  logic [63:0] in_valC;
  logic [3:0]  in_dstE;
  logic [3:0]  in_dstM;

  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_stat;
  logic [3:0]  out_icode;
  logic        out_cnd;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic [3:0]  out_dstE;
  logic [3:0]  out_dstM;

  logic [2:0]  cc;

  modport master (
    output in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, out_ready,
    input  in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE,
           out_valA, out_dstE, out_dstM, cc
  );

  modport slave (
    input  in_valid, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, out_ready,
    output in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE,
           out_valA, out_dstE, out_dstM, cc
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage_alu64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu64                                                          |
// | Purpose   : Combinational 64-bit ALU (add/sub/and/xor) with Y86 flags.     |
// |   aluA_i, aluB_i : operands (SUB computes aluB - aluA)                     |
// |   fn_i           : ALU function                                            |
// |   valE_o         : result; zf_o/sf_o/of_o : flags for this result          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module alu64
  import y86_pkg::*;
(
  input  logic [63:0] aluA_i,
  input  logic [63:0] aluB_i,
  input  alu_fn_e     fn_i,
  output logic [63:0] valE_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  logic [63:0] sum;
  logic [63:0] diff;

  assign sum  = aluB_i + aluA_i;
  assign diff = aluB_i - aluA_i;

  always_comb begin
    valE_o = sum;
    of_o   = 1'b0;
    case (fn_i)
      ADD: begin
        valE_o = sum;
        // Same-sign operands producing a result of the other sign
        of_o   = (aluA_i[63] == aluB_i[63]) && (sum[63] != aluA_i[63]);
      end
      SUB: begin
        valE_o = diff;
        of_o   = (aluA_i[63] != aluB_i[63]) && (diff[63] != aluB_i[63]);
      end
      AND:     valE_o = aluA_i & aluB_i;
      XOR:     valE_o = aluA_i ^ aluB_i;
      default: valE_o = sum;
    endcase
  end

  assign zf_o = (valE_o == 64'd0);
  assign sf_o = valE_o[63];

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : execute_stage                                                  |
// | Purpose   : Y86-64 execute stage. Selects ALU operands, computes valE,     |
// |             owns the condition codes, evaluates Cnd for cmovXX/jXX, holds  |
// |             a halt latch and registers the result for the memory stage.    |
// |   clk, rst : clock, asynchronous active-high reset                         |
// |   bus      : execute_stage_if.slave (in_* handshake, out_* handshake, cc)  |
// | Option    : EXEC_SKID_BUF_EN adds a one-entry skid buffer behind the       |
// |             output register and makes in_ready a register output.          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module execute_stage
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  execute_stage_if.slave   bus
);

  logic [63:0] alu_a, alu_b, alu_val_e;
  alu_fn_e     alu_fn;
  logic        alu_zf, alu_sf, alu_of;
  logic        cnd;
  logic        accept;
  logic        in_ready;
  exec_res_t   res_new;

  logic [2:0]  cc_q, cc_d;
  logic        halted_q, halted_d;
  exec_res_t   out_q, out_d;
  logic        out_valid_q, out_valid_d;

  // Operand selection
  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    case (bus.in_icode)
      RRMOVQ, OPQ:            alu_a = bus.in_valA;
      IRMOVQ, RMMOVQ, MRMOVQ: alu_a = bus.in_valC;
      CALL, PUSHQ:            alu_a = -64'd8;
      RET, POPQ:              alu_a = 64'd8;
      default:                alu_a = 64'd0;
    endcase
    case (bus.in_icode)
      RMMOVQ, MRMOVQ, OPQ, CALL, RET, PUSHQ, POPQ: alu_b = bus.in_valB;
      default:                                     alu_b = 64'd0;
    endcase
  end

  assign alu_fn = (bus.in_icode == OPQ) ? alu_fn_e'(bus.in_ifun[1:0]) : ADD;

  alu64 u_alu (
    .aluA_i (alu_a),
    .aluB_i (alu_b),
    .fn_i   (alu_fn),
    .valE_o (alu_val_e),
    .zf_o   (alu_zf),
    .sf_o   (alu_sf),
    .of_o   (alu_of)
  );

  // Cnd sees the flags as they stand before this instruction is applied
  assign cnd = cond_eval(bus.in_ifun, cc_q);

  always_comb begin
    res_new       = RES_RESET;
    res_new.stat  = bus.in_stat;
    res_new.icode = bus.in_icode;
    res_new.cnd   = ((bus.in_icode == RRMOVQ) || (bus.in_icode == JXX)) ? cnd : 1'b1;
    res_new.valE  = alu_val_e;
    res_new.valA  = bus.in_valA;
    // A cmov that is not taken writes no register
    res_new.dstE  = ((bus.in_icode == RRMOVQ) && !cnd) ? RNONE : bus.in_dstE;
    res_new.dstM  = bus.in_dstM;
  end

  assign cc_d     = (accept && (bus.in_icode == OPQ) && (bus.in_stat == AOK))
                    ? {alu_zf, alu_sf, alu_of} : cc_q;
  assign halted_d = halted_q | (accept && (bus.in_stat != AOK));

`ifdef EXEC_SKID_BUF_EN
  exec_res_t skid_q, skid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign accept   = bus.in_valid && in_ready_q;

  // in_ready_q is only high while the skid entry is empty, so an accept
  // never coincides with a pending skid entry.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = res_new;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = res_new;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !halted_d && !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q       <= RES_RESET;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !halted_q && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = res_new;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q        <= 3'b100;
      halted_q    <= 1'b0;
      out_q       <= RES_RESET;
      out_valid_q <= 1'b0;
    end else begin
      cc_q        <= cc_d;
      halted_q    <= halted_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_stat  = out_q.stat;
  assign bus.out_icode = out_q.icode;
  assign bus.out_cnd   = out_q.cnd;
  assign bus.out_valE  = out_q.valE;
  assign bus.out_valA  = out_q.valA;
  assign bus.out_dstE  = out_q.dstE;
  assign bus.out_dstM  = out_q.dstM;
  assign bus.cc        = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_execute_stage                                               |
// | Purpose   : Self-checking bench for execute_stage: directed vector table,  |
// |             stall / halt / reset sequences and randomized traffic against  |
// |             a behavioural model of the stage.                              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_execute_stage;
  import y86_pkg::*;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } instr_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } res_t;

  typedef struct packed {
    instr_t      ins;
    logic [63:0] e_valE;
    logic        e_cnd;
    logic [3:0]  e_dstE;
    logic [2:0]  e_cc;
  } vec_t;

`ifdef EXEC_SKID_BUF_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if bus();
  execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  res_t exp_q[$];
  logic [2:0] m_cc = 3'b100;
  bit   m_halt = 1'b0;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [3:0] de, input logic [3:0] dm);
    instr_t r;
    r.stat = st; r.icode = ic; r.ifun = fn; r.valA = a; r.valB = b; r.valC = c;
    r.dstE = de; r.dstM = dm;
    return r;
  endfunction

  // Reference: what the memory stage should receive, and the flags afterwards
  function automatic res_t ref_exec(input instr_t ins, input logic [2:0] ccv,
                                    output logic [2:0] cc_new);
    logic [63:0] a, b, e;
    logic [64:0] wide;
    logic        zf, sf, of, c, z0, s0, o0;
    res_t        r;
    case (ins.icode)
      4'h2, 4'h6:        a = ins.valA;
      4'h3, 4'h4, 4'h5:  a = ins.valC;
      4'h8, 4'hA:        a = -64'd8;
      4'h9, 4'hB:        a = 64'd8;
      default:           a = 64'd0;
    endcase
    b = (ins.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? ins.valB : 64'd0;
    of = 1'b0;
    wide = '0;
    if (ins.icode != 4'h6 || ins.ifun[1:0] == 2'd0) begin
      wide = {a[63], a} + {b[63], b};
      e = wide[63:0];
      of = wide[64] != wide[63];
    end else if (ins.ifun[1:0] == 2'd1) begin
      wide = {b[63], b} - {a[63], a};
      e = wide[63:0];
      of = wide[64] != wide[63];
    end else if (ins.ifun[1:0] == 2'd2) e = a & b;
    else e = a ^ b;
    zf = (e == 64'd0);
    sf = e[63];
    cc_new = (ins.icode == 4'h6 && ins.stat == 3'd1) ? {zf, sf, of} : ccv;
    {z0, s0, o0} = ccv;
    case (ins.ifun)
      4'd0: c = 1'b1;
      4'd1: c = (s0 != o0) || z0;
      4'd2: c = (s0 != o0);
      4'd3: c = z0;
      4'd4: c = !z0;
      4'd5: c = (s0 == o0);
      4'd6: c = (s0 == o0) && !z0;
      default: c = 1'b0;
    endcase
    r.stat  = ins.stat;
    r.icode = ins.icode;
    r.cnd   = (ins.icode == 4'h2 || ins.icode == 4'h7) ? c : 1'b1;
    r.valE  = e;
    r.valA  = ins.valA;
    r.dstE  = (ins.icode == 4'h2 && !c) ? 4'hF : ins.dstE;
    r.dstM  = ins.dstM;
    return r;
  endfunction

  // One clock: drive after the edge, check at the negedge, then advance the
  // model for the transfers the coming edge will perform.
  task automatic step(input logic v, input instr_t ins, input logic ordy);
    logic       exp_rdy;
    logic [2:0] ncc;
    int         cnt;
    res_t       r;
    @(posedge clk); #1;
    bus.in_valid = v;     bus.in_stat = ins.stat; bus.in_icode = ins.icode;
    bus.in_ifun = ins.ifun; bus.in_valA = ins.valA; bus.in_valB = ins.valB;
    bus.in_valC = ins.valC; bus.in_dstE = ins.dstE; bus.in_dstM = ins.dstM;
    bus.out_ready = ordy;
    @(negedge clk);
    cnt = exp_q.size();
`ifdef EXEC_SKID_BUF_EN
    exp_rdy = !m_halt && (cnt <= 1);
`else
    exp_rdy = !m_halt && (cnt == 0 || ordy);
`endif
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, cnt > 0);
    chk("cc", bus.cc, m_cc);
    if (cnt > 0) begin
      r = exp_q[0];
      chk("out_valE", bus.out_valE, r.valE);
      chk("out_valA", bus.out_valA, r.valA);
      chk("out_ctl", {bus.out_stat, bus.out_icode, bus.out_cnd, bus.out_dstE, bus.out_dstM},
          {r.stat, r.icode, r.cnd, r.dstE, r.dstM});
      if (ordy) void'(exp_q.pop_front());
    end
    if (v && exp_rdy) begin
      exp_q.push_back(ref_exec(ins, m_cc, ncc));
      m_cc = ncc;
      if (ins.stat != 3'd1) m_halt = 1'b1;
      n_acc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst cc", bus.cc, 3'b100);
    chk("rst out_cnd", bus.out_cnd, 0);
    chk("rst out_valE", bus.out_valE, 0);
    chk("rst dst", {bus.out_dstE, bus.out_dstM}, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_cc = 3'b100;
    m_halt = 1'b0;
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.icode = 4'($urandom_range(0, 11));
    r.ifun  = (r.icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
    r.valA  = rand_val();
    r.valB  = ($urandom_range(0, 5) == 0) ? r.valA : rand_val();
    r.valC  = rand_val();
    r.dstE  = 4'($urandom_range(0, 15));
    r.dstM  = 4'($urandom_range(0, 15));
    r.stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t idle;
    idle = mk(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    bus.in_valid = 1'b0; bus.in_stat = 3'd1; bus.in_icode = 4'h1; bus.in_ifun = 4'h0;
    bus.in_valA = '0; bus.in_valB = '0; bus.in_valC = '0;
    bus.in_dstE = 4'hF; bus.in_dstM = 4'hF; bus.out_ready = 1'b1;

    //          ins                                                                        valE                   cnd   dstE   cc
    tbl[0] = '{mk(1, 6, 3, 64'hF0F0, 64'hFF00, 0, 4'h3, 4'hF),                             64'h0FF0,              1'b1, 4'h3, 3'b000};
    tbl[1] = '{mk(1, 6, 1, 64'd1, 64'h8000_0000_0000_0000, 0, 4'h3, 4'hF),                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'h3, 3'b001};
    tbl[2] = '{mk(1, 7, 2, 64'h11, 64'h77, 64'h400, 4'hF, 4'hF),                           64'd0,                 1'b1, 4'hF, 3'b001};
    tbl[3] = '{mk(1, 6, 0, -64'd5, 64'd5, 0, 4'h3, 4'hF),                                  64'd0,                 1'b1, 4'h3, 3'b100};
    tbl[4] = '{mk(1, 2, 4, 64'h1234, 64'h99, 0, 4'h3, 4'hF),                               64'h1234,              1'b0, 4'hF, 3'b100};
    tbl[5] = '{mk(1, 4'hA, 0, 64'h5, 64'h100, 0, 4'h4, 4'hF),                              64'hF8,                1'b1, 4'h4, 3'b100};
    tbl[6] = '{mk(1, 4'hB, 0, 64'hF8, 64'hF8, 0, 4'h4, 4'h1),                              64'h100,               1'b1, 4'h4, 3'b100};
    tbl[7] = '{mk(1, 3, 0, 64'h9, 64'h9, 64'h55, 4'h2, 4'hF),                              64'h55,                1'b1, 4'h2, 3'b100};
    tbl[8] = '{mk(1, 2, 1, 64'hABC, 64'h0, 0, 4'h3, 4'hF),                                 64'hABC,               1'b1, 4'h3, 3'b100};

    do_reset();

    // Directed vectors, one in flight at a time
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].ins, 1'b1);
      step(1'b0, idle, 1'b1);
      chk($sformatf("tbl[%0d] valE", i), bus.out_valE, tbl[i].e_valE);
      chk($sformatf("tbl[%0d] cnd", i), bus.out_cnd, tbl[i].e_cnd);
      chk($sformatf("tbl[%0d] dstE", i), bus.out_dstE, tbl[i].e_dstE);
      chk($sformatf("tbl[%0d] cc", i), bus.cc, tbl[i].e_cc);
    end
    step(1'b0, idle, 1'b1);

    // Back-pressure: three cycles of offers against a stalled output
    n_acc = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(1, 6, 0, 64'(i + 1), 64'd100, 0, 4'h2, 4'hF), 1'b0);
    chk("stall accepts", n_acc, STALL_ACCEPTS);
    chk("stall in_ready", bus.in_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1);

    // Halt latch, then reset while the halting instruction is stalled
    step(1'b1, mk(3'd2, 4'h0, 4'h0, 64'h1, 64'h2, 64'h3, 4'hF, 4'hF), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(1, 6, 0, 64'd1, 64'd1, 0, 4'h1, 4'hF), 1'b0);
    chk("halt out_stat", bus.out_stat, 3'd2);
    chk("halt in_ready", bus.in_ready, 0);
    do_reset();
    step(1'b0, idle, 1'b1);
    chk("post-reset in_ready", bus.in_ready, 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7);
      if (m_halt && $urandom_range(0, 5) == 0) do_reset();
    end
    for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
